// File: rtl/seq_pkg.sv
// Shared state codes, defaults and helpers for the serial pattern generator.
// State codes double as the LED debug encoding.
package seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_SEND = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam int unsigned DEF_RUN_LEN = 4;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND,
        DONE = ST_DONE
    } state_t;

    function automatic logic len_legal(input int unsigned len, input int unsigned pat_w);
        return (len != 0) && (len <= pat_w);
    endfunction

endpackage

// File: rtl/seq_run_tracker.sv
// Golden model of the sequence detector's z: counts equal consecutive beats
// and raises z (registered, Moore timing) once RUN_LEN of them have been seen.
module seq_run_tracker
    import seq_pkg::*;
#(
    parameter int unsigned RUN_LEN = DEF_RUN_LEN
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic clr,
    input  logic beat,
    input  logic beat_bit,
    output logic z
);

    localparam int unsigned RUN_W = $clog2(RUN_LEN + 1);

    logic             r_last_bit;
    logic [RUN_W-1:0] r_run;
    logic             r_z;
    logic [RUN_W-1:0] w_run_nxt;

    // Saturate at RUN_LEN so a long run keeps z high without wrapping.
    always_comb begin
        w_run_nxt = RUN_W'(1);
        if ((r_run != '0) && (beat_bit == r_last_bit))
            w_run_nxt = (r_run == RUN_W'(RUN_LEN)) ? r_run : r_run + RUN_W'(1);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_last_bit <= 1'b0;
            r_run      <= '0;
            r_z        <= 1'b0;
        end else if (clr) begin
            r_last_bit <= 1'b0;
            r_run      <= '0;
            r_z        <= 1'b0;
        end else if (beat) begin
            r_last_bit <= beat_bit;
            r_run      <= w_run_nxt;
            r_z        <= (w_run_nxt == RUN_W'(RUN_LEN));
        end
    end

    assign z = r_z;

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial stimulus source for the sequence detector: shifts a parallel pattern
// out MSB-first, optionally repeating, and provides a golden z for comparison.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start with a legal length
//   SEND  | one bit per non-held cycle; reloads on last beat if repeating
//   DONE  | one-cycle completion pulse, then back to IDLE
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W   = 16,
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned RUN_LEN = DEF_RUN_LEN
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] length,
    input  logic             repeat_en,
    input  logic             hold,
    output logic             w_out,
    output logic             w_valid,
    output logic             busy,
    output logic             done,
    output logic             z_expect,
    output logic [1:0]       state_dbg
);

    state_t           r_state;
    logic [PAT_W-1:0] r_shift;
    logic [CNT_W-1:0] r_count;

    logic w_len_ok;
    logic w_beat;
    logic w_load;

    assign w_len_ok = len_legal(int'(length), PAT_W);
    assign w_beat   = (r_state == SEND) && !hold;
    assign w_load   = (r_state == IDLE) && start && w_len_ok;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_shift <= pattern;
                        r_count <= length;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_beat) begin
                        if (r_count == CNT_W'(1)) begin
                            // Repeat reload samples the live ports; an illegal length ends the run.
                            if (repeat_en && w_len_ok) begin
                                r_shift <= pattern;
                                r_count <= length;
                            end else begin
                                r_shift <= r_shift << 1;
                                r_count <= '0;
                                r_state <= DONE;
                            end
                        end else begin
                            r_shift <= r_shift << 1;
                            r_count <= r_count - CNT_W'(1);
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    seq_run_tracker #(
        .RUN_LEN (RUN_LEN)
    ) u_run_tracker (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .clr      (w_load),
        .beat     (w_beat),
        .beat_bit (w_out),
        .z        (z_expect)
    );

    assign w_out     = r_shift[PAT_W-1];
    assign w_valid   = w_beat;
    assign busy      = (r_state == SEND);
    assign done      = (r_state == DONE);
    assign state_dbg = r_state;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: directed and randomized transfers
// compared against an expected-bit list and a bit-history run model.
module tb_seq_pattern_gen;

    localparam int PAT_W   = 16;
    localparam int CNT_W   = 5;
    localparam int RUN_LEN = 4;

    logic             Clock = 1'b0;
    logic             Resetn = 1'b0;
    logic             start = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] length = '0;
    logic             repeat_en = 1'b0;
    logic             hold = 1'b0;
    logic             w_out, w_valid, busy, done, z_expect;
    logic [1:0]       state_dbg;

    int checks = 0;
    int errors = 0;
    bit hist[$];

    always #5 Clock = ~Clock;

    seq_pattern_gen #(
        .PAT_W   (PAT_W),
        .CNT_W   (CNT_W),
        .RUN_LEN (RUN_LEN)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .start     (start),
        .pattern   (pattern),
        .length    (length),
        .repeat_en (repeat_en),
        .hold      (hold),
        .w_out     (w_out),
        .w_valid   (w_valid),
        .busy      (busy),
        .done      (done),
        .z_expect  (z_expect),
        .state_dbg (state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // z is high when the last RUN_LEN emitted bits since the last start agree.
    function automatic logic model_z();
        int n;
        n = hist.size();
        if (n < RUN_LEN) return 1'b0;
        for (int k = 1; k < RUN_LEN; k++)
            if (hist[n-1-k] != hist[n-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_w_out"},   32'(w_out),     32'd0);
        chk({tag, "_w_valid"}, 32'(w_valid),   32'd0);
        chk({tag, "_busy"},    32'(busy),      32'd0);
        chk({tag, "_done"},    32'(done),      32'd0);
        chk({tag, "_z"},       32'(z_expect),  32'd0);
        chk({tag, "_state"},   32'(state_dbg), 32'd0);
    endtask

    // Called at posedge+1. Sends frames*len bits; hold_at/hold_n force a hold
    // burst before beat index hold_at; abort_at pulls reset before that beat.
    task automatic transfer(input logic [PAT_W-1:0] pat, input int len, input int frames,
                            input int hold_pct, input int hold_at, input int hold_n,
                            input bit bad_reload, input int abort_at);
        bit exp_bits[$];
        int beat;
        int held;
        int cyc;
        int total;
        bit last_frame;
        beat = 0;
        held = 0;
        cyc  = 0;
        for (int f = 0; f < frames; f++)
            for (int i = 0; i < len; i++)
                exp_bits.push_back(pat[PAT_W-1-i]);
        total = frames * len;

        pattern   = pat;
        length    = CNT_W'(len);
        start     = 1'b1;
        hold      = 1'b0;
        repeat_en = (frames > 1);
        @(negedge Clock);
        chk("start_cycle_idle", 32'(state_dbg), 32'd0);
        next_cycle();
        start = 1'b0;
        hist.delete();

        while (beat < total) begin
            if (cyc > total * 8 + 40) begin
                chk("timeout_beats", beat, total);
                break;
            end
            last_frame = ((beat / len) == frames - 1);
            start      = 1'($urandom_range(1, 0));
            repeat_en  = !last_frame || bad_reload;
            length     = (last_frame && bad_reload) ? '0 : CNT_W'(len);
            if (beat == hold_at && held < hold_n) begin
                hold = 1'b1;
                held++;
            end else begin
                hold = ($urandom_range(99, 0) < hold_pct);
            end
            if (beat == abort_at) begin
                hold = 1'b0;
                #1 Resetn = 1'b0;
                #1;
                check_all_zero("abort");
                next_cycle();
                check_all_zero("abort_held");
                start  = 1'b0;
                Resetn = 1'b1;
                @(negedge Clock);
                chk("abort_idle",   32'(state_dbg), 32'd0);
                chk("abort_nodone", 32'(done),      32'd0);
                next_cycle();
                return;
            end
            @(negedge Clock);
            chk("busy",      32'(busy),      32'd1);
            chk("state_snd", 32'(state_dbg), 32'd1);
            chk("w_valid",   32'(w_valid),   32'(!hold));
            chk("w_out",     32'(w_out),     32'(exp_bits[beat]));
            chk("z_expect",  32'(z_expect),  32'(model_z()));
            chk("done_snd",  32'(done),      32'd0);
            if (!hold) begin
                hist.push_back(exp_bits[beat]);
                beat++;
            end
            cyc++;
            next_cycle();
        end

        // DONE cycle; a start here must be ignored.
        start     = 1'b1;
        length    = CNT_W'(len);
        repeat_en = 1'b0;
        hold      = 1'b0;
        @(negedge Clock);
        chk("done_pulse", 32'(done),      32'd1);
        chk("done_state", 32'(state_dbg), 32'd2);
        chk("done_busy",  32'(busy),      32'd0);
        chk("done_valid", 32'(w_valid),   32'd0);
        chk("done_z",     32'(z_expect),  32'(model_z()));
        next_cycle();
        start = 1'b0;
        @(negedge Clock);
        chk("after_done",  32'(done),      32'd0);
        chk("after_state", 32'(state_dbg), 32'd0);
        chk("after_z",     32'(z_expect),  32'(model_z()));
        next_cycle();
    endtask

    initial begin
        Resetn  = 1'b0;
        start   = 1'b1;
        pattern = 16'hA5A5;
        length  = 5'd8;
        repeat (3) begin
            @(negedge Clock);
            check_all_zero("reset");
            hold    = 1'($urandom_range(1, 0));
            pattern = PAT_W'($urandom);
            start   = 1'($urandom_range(1, 0));
        end
        next_cycle();
        start  = 1'b0;
        hold   = 1'b0;
        Resetn = 1'b1;
        repeat (3) begin
            @(negedge Clock);
            check_all_zero("post_reset");
        end
        next_cycle();

        // Illegal lengths: start ignored.
        start   = 1'b1;
        pattern = 16'hFFFF;
        length  = 5'd0;
        repeat (3) begin
            @(negedge Clock);
            chk("len0_state", 32'(state_dbg), 32'd0);
            chk("len0_busy",  32'(busy),      32'd0);
        end
        next_cycle();
        length = 5'd17;
        repeat (3) begin
            @(negedge Clock);
            chk("len17_state", 32'(state_dbg), 32'd0);
        end
        next_cycle();
        start = 1'b0;

        transfer(16'hF0F0, 8, 1, 0, -1, 0, 1'b0, -1);
        transfer(16'hF0F0, 8, 1, 0, 2, 3, 1'b0, -1);
        transfer(16'hC000, 3, 4, 0, -1, 0, 1'b0, -1);
        transfer(16'hFFFF, 16, 1, 0, -1, 0, 1'b0, -1);
        transfer(16'hF0F0, 8, 1, 0, -1, 0, 1'b0, 4);
        transfer(16'h3C5A, 8, 1, 0, -1, 0, 1'b0, -1);
        transfer(16'h8000, 1, 3, 0, -1, 0, 1'b0, -1);
        transfer(16'hAAAA, 5, 2, 0, -1, 0, 1'b1, -1);

        for (int t = 0; t < 20; t++) begin
            int len_r;
            int frm_r;
            len_r = $urandom_range(PAT_W, 1);
            frm_r = $urandom_range(3, 1);
            transfer(PAT_W'($urandom), len_r, frm_r, $urandom_range(40, 0),
                     -1, 0, 1'($urandom_range(1, 0)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
